bram_sp_fifo_ctrl: RTL and testbench

//   Upstream controller for bram_sync_sp: turns it into a valid/ready stream FIFO.

---
 rtl/bram_sp_fifo_ctrl_if.sv | 33 +++
 rtl/bram_sp_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_bram_sp_fifo_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_sp_fifo_ctrl_if.sv
// Stream and BRAM-port signal bundle for bram_sp_fifo_ctrl.
// master = the controller side, slave = the producer/consumer/BRAM environment.
interface bram_sp_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH+1:0] count;
    logic                  full;
    logic                  empty;
    logic                  bram_en;
    logic                  bram_wr;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport master (
        input  s_valid, s_data, m_ready, bram_dout,
        output s_ready, m_valid, m_data, count, full, empty,
               bram_en, bram_wr, bram_addr, bram_din
    );

    modport slave (
        output s_valid, s_data, m_ready, bram_dout,
        input  s_ready, m_valid, m_data, count, full, empty,
               bram_en, bram_wr, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_sp_fifo_ctrl.sv
// Valid/ready FIFO controller around a single-port synchronous BRAM: round-robin
// write/read arbitration of the one RAM port plus a 2-entry skid for read latency.
module bram_sp_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bram_sp_fifo_ctrl_if.master bus
);
    localparam int SKID_DEPTH = 2;
    localparam logic [ADDR_WIDTH:0]   MEM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic                  r_inflight;
    logic                  r_last_wr;
    logic [1:0]            r_sk_cnt;
    logic [DATA_WIDTH-1:0] r_sk_data [SKID_DEPTH];

    logic                  w_rd_req;
    logic                  w_s_ready;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [1:0]            w_sk_base;
    logic [ADDR_WIDTH+1:0] w_count;
    logic [DATA_WIDTH-1:0] w_sk_shift [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] w_sk_next  [SKID_DEPTH];

    // Requests use registered state only, so s_ready never depends on s_valid.
    assign w_occ      = r_sk_cnt + {1'b0, r_inflight};
    assign w_rd_req   = rst_n && (r_mem_cnt != '0) && (w_occ < 2'd2);
    assign w_s_ready  = rst_n && (r_mem_cnt != MEM_FULL) && !(w_rd_req && r_last_wr);
    assign w_grant_wr = bus.s_valid && w_s_ready;
    assign w_grant_rd = w_rd_req && !w_grant_wr;

    assign w_push    = r_inflight;
    assign w_pop     = (r_sk_cnt != 2'd0) && bus.m_ready;
    assign w_sk_base = r_sk_cnt - {1'b0, w_pop};

    assign w_count = (ADDR_WIDTH+2)'(r_mem_cnt)
                   + (ADDR_WIDTH+2)'(r_inflight)
                   + (ADDR_WIDTH+2)'(r_sk_cnt);

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = (r_sk_cnt != 2'd0);
    assign bus.m_data    = r_sk_data[0];
    assign bus.count     = w_count;
    assign bus.full      = (r_mem_cnt == MEM_FULL);
    assign bus.empty     = (w_count == '0);
    assign bus.bram_en   = w_grant_wr || w_grant_rd;
    assign bus.bram_wr   = w_grant_wr;
    assign bus.bram_addr = w_grant_wr ? r_wr_ptr : r_rd_ptr;
    assign bus.bram_din  = bus.s_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_last_wr  <= 1'b0;
            r_sk_cnt   <= 2'd0;
        end else begin
            if (w_grant_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_grant_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_grant_wr, w_grant_rd})
                2'b10:   r_mem_cnt <= r_mem_cnt + CNT_ONE;
                2'b01:   r_mem_cnt <= r_mem_cnt - CNT_ONE;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            r_inflight <= w_grant_rd;
            if (w_grant_wr) begin
                r_last_wr <= 1'b1;
            end else if (w_grant_rd) begin
                r_last_wr <= 1'b0;
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Each skid slot either takes the returning BRAM word (tail after any pop),
    // shifts toward the head on a pop, or holds.
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
        if (gi == SKID_DEPTH - 1) begin : g_tail
            assign w_sk_shift[gi] = r_sk_data[gi];
        end else begin : g_body
            assign w_sk_shift[gi] = r_sk_data[gi+1];
        end
        assign w_sk_next[gi] = (w_push && (w_sk_base == 2'(gi))) ? bus.bram_dout
                             : (w_pop ? w_sk_shift[gi] : r_sk_data[gi]);
    end

    always_ff @(posedge clk) begin
        r_sk_data <= w_sk_next;
    end
endmodule

// File: tb/tb_bram_sp_fifo_ctrl.sv
// Bench for bram_sp_fifo_ctrl with a behavioural 1-cycle-latency BRAM and a queue reference model.
module tb_bram_sp_fifo_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_sp_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_sp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port BRAM: registered read, one access per cycle.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (bus.bram_wr) ram[bus.bram_addr] <= bus.bram_din;
            else             ram_q <= ram[bus.bram_addr];
        end
    end
    assign bus.bram_dout = ram_q;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: words accepted but not yet delivered, in order; nth write lands at n mod DEPTH.
    logic [DW-1:0] ref_q [$];
    int            n_wr_seen;

    task automatic model_cycle(output logic acc, output logic del, output logic [DW-1:0] exp_head,
                               output int exp_cnt, output int exp_waddr);
        acc       = bus.s_valid && bus.s_ready;
        del       = bus.m_valid && bus.m_ready;
        exp_cnt   = ref_q.size();
        exp_head  = (ref_q.size() != 0) ? ref_q[0] : '0;
        exp_waddr = n_wr_seen % DEPTH;
        if (del && ref_q.size() != 0) void'(ref_q.pop_front());
        if (acc) begin
            ref_q.push_back(bus.s_data);
            n_wr_seen++;
        end
        if (del) $display("t=%0t out data=%08h count=%0d", $time, bus.m_data, bus.count);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        ref_q.delete();
        n_wr_seen = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 32'h1234_5678;
        bus.m_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready); else n_pass++;
        n_checks++; if (bus.bram_en !== 1'b0) $display("FAIL rst_bram_en got=%b exp=0", bus.bram_en); else n_pass++;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.count !== '0) $display("FAIL rst_count got=%0d exp=0", bus.count); else n_pass++;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL rst_full got=%b exp=0", bus.full); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", bus.empty); else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL post_rst_s_ready got=%b exp=1", bus.s_ready); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL post_rst_empty got=%b exp=1", bus.empty); else n_pass++;
        next_cycle();
        ref_q.delete();
        n_wr_seen = 0;
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.s_valid = 1'b0;
            bus.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++; if (bus.bram_en !== 1'b0) $display("FAIL idle_bram_en c=%0d got=%b exp=0", c, bus.bram_en); else n_pass++;
            n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL idle_m_valid c=%0d got=%b exp=0", c, bus.m_valid); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_latency();
        do_reset();
        bus.s_valid = 1'b1;
        bus.s_data = 32'hA5A5_A5A5;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL lat_accept got=%b exp=1", bus.s_ready); else n_pass++;
            end
            n_checks++;
            if (bus.m_valid !== (c == 3)) $display("FAIL lat_m_valid c=%0d got=%b exp=%b", c, bus.m_valid, (c == 3));
            else n_pass++;
            if (c == 3) begin
                n_checks++;
                if (bus.m_data !== 32'hA5A5_A5A5) $display("FAIL lat_m_data got=%08h exp=a5a5a5a5", bus.m_data);
                else n_pass++;
                $display("t=%0t out data=%08h latency=3", $time, bus.m_data);
            end
            next_cycle();
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic test_fill();
        logic acc, del;
        logic [DW-1:0] exp_head;
        int exp_cnt, exp_waddr, word, n_out;
        do_reset();
        word = 0;
        for (int c = 0; c < 80; c++) begin
            bus.s_valid = (word < 20);
            bus.s_data = DW'(word);
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            n_checks++; if (bus.count !== 6'(exp_cnt)) $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, bus.count, exp_cnt); else n_pass++;
            if (acc) word++;
            next_cycle();
        end
        n_checks++; if (word !== CAP) $display("FAIL fill_accepted got=%0d exp=%0d", word, CAP); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL fill_s_ready got=%b exp=0", bus.s_ready); else n_pass++;
        n_checks++; if (bus.count !== 6'(CAP)) $display("FAIL fill_count_full got=%0d exp=%0d", bus.count, CAP); else n_pass++;
        n_checks++; if (bus.full !== 1'b1) $display("FAIL fill_full got=%b exp=1", bus.full); else n_pass++;
        next_cycle();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 100 && n_out < CAP; c++) begin
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            if (del) begin
                n_checks++;
                if (bus.m_data !== DW'(n_out)) $display("FAIL drain_data got=%08h exp=%08h", bus.m_data, n_out);
                else n_pass++;
                n_out++;
            end
            next_cycle();
        end
        n_checks++; if (n_out !== CAP) $display("FAIL drain_words got=%0d exp=%0d", n_out, CAP); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.full !== 1'b0) $display("FAIL drain_full got=%b exp=0", bus.full); else n_pass++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic acc, del, prev_wr;
        logic [DW-1:0] exp_head;
        int exp_cnt, exp_waddr, word, acc_win, del_win;
        do_reset();
        word = 0; acc_win = 0; del_win = 0; prev_wr = 1'b0;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus.s_data = DW'(word);
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            if (del) begin
                n_checks++;
                if (bus.m_data !== exp_head) $display("FAIL sat_data got=%08h exp=%08h", bus.m_data, exp_head);
                else n_pass++;
            end
            if (c >= 20) begin
                n_checks++; if (bus.bram_en !== 1'b1) $display("FAIL sat_bram_en c=%0d got=%b exp=1", c, bus.bram_en); else n_pass++;
                n_checks++; if (bus.bram_wr !== ~prev_wr) $display("FAIL sat_alternate c=%0d got=%b exp=%b", c, bus.bram_wr, ~prev_wr); else n_pass++;
                if (acc) acc_win++;
                if (del) del_win++;
            end
            prev_wr = bus.bram_wr;
            if (acc) word++;
            next_cycle();
        end
        n_checks++; if (acc_win !== 20) $display("FAIL sat_in_rate got=%0d exp=20", acc_win); else n_pass++;
        n_checks++; if (del_win !== 20) $display("FAIL sat_out_rate got=%0d exp=20", del_win); else n_pass++;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic acc, del, pending;
        logic [DW-1:0] exp_head;
        int exp_cnt, exp_waddr, sent, n_out, wraps;
        do_reset();
        sent = 0; n_out = 0; wraps = 0; pending = 1'b0;
        for (int c = 0; c < 4000 && n_out < 100; c++) begin
            if (!pending && sent < 100 && $urandom_range(0, 2) != 0) begin
                pending = 1'b1;
                bus.s_data = $urandom;
            end
            bus.s_valid = pending;
            bus.m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            n_checks++; if (bus.count !== 6'(exp_cnt)) $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, bus.count, exp_cnt); else n_pass++;
            n_checks++; if (int'(bus.count) > CAP) $display("FAIL wrap_cap c=%0d got=%0d exp<=%0d", c, bus.count, CAP); else n_pass++;
            n_checks++; if ((bus.bram_en && bus.bram_wr) !== acc) $display("FAIL wrap_wr_grant c=%0d got=%b exp=%b", c, bus.bram_en && bus.bram_wr, acc); else n_pass++;
            if (acc) begin
                n_checks++;
                if (bus.bram_addr !== AW'(exp_waddr)) $display("FAIL wrap_waddr got=%0d exp=%0d", bus.bram_addr, exp_waddr);
                else n_pass++;
                if (exp_waddr == DEPTH - 1) wraps++;
                pending = 1'b0;
                sent++;
            end
            if (del) begin
                n_checks++;
                if (bus.m_data !== exp_head) $display("FAIL wrap_data n=%0d got=%08h exp=%08h", n_out, bus.m_data, exp_head);
                else n_pass++;
                n_out++;
            end
            next_cycle();
        end
        n_checks++; if (n_out !== 100) $display("FAIL wrap_words got=%0d exp=100", n_out); else n_pass++;
        n_checks++; if (wraps < 5) $display("FAIL wrap_count_wraps got=%0d exp>=5", wraps); else n_pass++;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic acc, del;
        logic [DW-1:0] exp_head;
        int exp_cnt, exp_waddr, sent, n_out;
        do_reset();
        sent = 0;
        bus.m_ready = 1'b0;
        for (int c = 0; c < 60 && sent < 7; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data = DW'(32'h100 + sent);
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            if (acc) sent++;
            next_cycle();
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.count !== 6'd7) $display("FAIL midop_count got=%0d exp=7", bus.count); else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL midop_rst_s_ready got=%b exp=0", bus.s_ready); else n_pass++;
        n_checks++; if (bus.bram_en !== 1'b0) $display("FAIL midop_rst_bram_en got=%b exp=0", bus.bram_en); else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        ref_q.delete();
        n_wr_seen = 0;
        @(negedge clk);
        n_checks++; if (bus.count !== '0) $display("FAIL midop_count0 got=%0d exp=0", bus.count); else n_pass++;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL midop_m_valid got=%b exp=0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL midop_empty got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.bram_en !== 1'b0) $display("FAIL midop_bram_en got=%b exp=0", bus.bram_en); else n_pass++;
        next_cycle();
        bus.s_valid = 1'b1;
        bus.s_data = 32'h1;
        bus.m_ready = 1'b1;
        n_out = 0;
        for (int c = 0; c < 20 && n_out == 0; c++) begin
            @(negedge clk);
            model_cycle(acc, del, exp_head, exp_cnt, exp_waddr);
            if (del) begin
                n_checks++;
                if (bus.m_data !== 32'h1) $display("FAIL midop_first_word got=%08h exp=00000001", bus.m_data);
                else n_pass++;
                n_out++;
            end
            next_cycle();
            if (acc) bus.s_valid = 1'b0;
        end
        n_checks++; if (n_out !== 1) $display("FAIL midop_first_timeout got=%0d exp=1", n_out); else n_pass++;
        bus.s_valid = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        n_wr_seen = 0;
        #1;
        test_reset();
        test_idle();
        test_latency();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
